// File: rtl/frag_input_buffer_ctrl.sv
// Input-buffer manager: writes fragments into PBM cells, issues flow lookups and
// enqueues {last_frag, bufid} (or returns the bufid) as lookup results come back.

module frag_pend_fifo #(
  parameter int W  = 11,
  parameter int AW = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] iv_wdata,
  input  logic         i_pop,
  output logic [W-1:0] ov_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full   = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty  = (r_cnt == '0);
  assign ov_rdata = r_mem[r_rp];
  assign w_pop    = i_pop && !o_empty;
  assign w_push   = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= iv_wdata;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module frag_input_buffer_ctrl #(
  parameter int BUFID_W   = 9,
  parameter int CELL_AW   = 3,
  parameter int QID_W     = 5,
  parameter int QDEPTH_AW = 4,
  parameter int PEND_AW   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [133:0]                  iv_pkt_data,
  input  logic                          i_pkt_data_wr,
  input  logic [BUFID_W-1:0]            iv_bufid,
  input  logic                          i_bufid_wr,
  output logic                          o_bufid_ack,
  output logic [133:0]                  ov_pkt_ram_wdata,
  output logic                          o_pkt_ram_wr,
  output logic [BUFID_W+CELL_AW-1:0]    ov_pkt_ram_waddr,
  output logic [13:0]                   ov_flowid,
  output logic [3:0]                    ov_frag_id,
  output logic                          o_last_frag_flag,
  output logic                          o_flowid_wr,
  input  logic [QID_W-1:0]              iv_queue_id,
  input  logic [QDEPTH_AW-1:0]          iv_queue_usedw,
  input  logic                          i_queue_id_wr,
  output logic [BUFID_W:0]              ov_queue_ram_wdata,
  output logic                          o_queue_ram_wr,
  output logic [QID_W+QDEPTH_AW-1:0]    ov_queue_ram_waddr,
  output logic [BUFID_W-1:0]            ov_free_bufid,
  output logic                          o_free_bufid_wr,
  output logic                          o_ibm_discard_pulse,
  output logic                          o_trunc_pulse,
  output logic                          o_qfull_discard_pulse,
  output logic                          o_lookup_err_pulse
);
  localparam int CNT_W      = CELL_AW + 1;
  localparam int CELL_BEATS = 1 << CELL_AW;
  localparam int QAW        = QID_W + QDEPTH_AW;

  typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;

  typedef struct packed {
    logic               err;
    logic               last;
    logic [BUFID_W-1:0] bufid;
  } pend_t;

  state_t             r_state;
  logic [BUFID_W-1:0] r_bufid;
  logic [13:0]        r_flowid;
  logic [3:0]         r_frag_id;
  logic               r_last;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [1:0]         w_typ;
  logic               w_head, w_tail, w_cell_full;
  logic               w_push, w_pop_req, w_full, w_empty;
  pend_t              w_push_ent, w_pop_ent;
  logic [$bits(pend_t)-1:0] w_rdata;

  assign w_typ       = iv_pkt_data[133:132];
  assign w_head      = i_pkt_data_wr && (w_typ == 2'b01);
  assign w_tail      = i_pkt_data_wr && (w_typ == 2'b10);
  assign w_cell_full = (r_cnt == CNT_W'(CELL_BEATS));

  // A tail that itself overflows the cell must already carry the err flag.
  assign w_push     = (r_state == TRANS) && w_tail;
  assign w_push_ent = '{err: r_err | w_cell_full, last: r_last, bufid: r_bufid};
  assign w_pop_req  = i_queue_id_wr;
  assign w_pop_ent  = pend_t'(w_rdata);

  frag_pend_fifo #(.W($bits(pend_t)), .AW(PEND_AW)) u_pend (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (w_push),
    .iv_wdata (w_push_ent),
    .i_pop    (w_pop_req),
    .ov_rdata (w_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state             <= IDLE;
      r_bufid             <= '0;
      r_flowid            <= '0;
      r_frag_id           <= '0;
      r_last              <= 1'b0;
      r_err               <= 1'b0;
      r_cnt               <= '0;
      o_bufid_ack         <= 1'b0;
      ov_pkt_ram_wdata    <= '0;
      o_pkt_ram_wr        <= 1'b0;
      ov_pkt_ram_waddr    <= '0;
      ov_flowid           <= '0;
      ov_frag_id          <= '0;
      o_last_frag_flag    <= 1'b0;
      o_flowid_wr         <= 1'b0;
      o_ibm_discard_pulse <= 1'b0;
      o_trunc_pulse       <= 1'b0;
    end else begin
      o_bufid_ack         <= 1'b0;
      ov_pkt_ram_wdata    <= '0;
      o_pkt_ram_wr        <= 1'b0;
      ov_pkt_ram_waddr    <= '0;
      ov_flowid           <= '0;
      ov_frag_id          <= '0;
      o_last_frag_flag    <= 1'b0;
      o_flowid_wr         <= 1'b0;
      o_ibm_discard_pulse <= 1'b0;
      o_trunc_pulse       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_head) begin
            if (i_bufid_wr && !w_full) begin
              ov_pkt_ram_wdata <= iv_pkt_data;
              o_pkt_ram_wr     <= 1'b1;
              ov_pkt_ram_waddr <= {iv_bufid, {CELL_AW{1'b0}}};
              o_bufid_ack      <= 1'b1;
              r_bufid          <= iv_bufid;
              r_flowid         <= iv_pkt_data[124:111];
              r_frag_id        <= iv_pkt_data[93:90];
              r_last           <= iv_pkt_data[94];
              r_err            <= 1'b0;
              r_cnt            <= CNT_W'(1);
              r_state          <= TRANS;
            end else begin
              o_ibm_discard_pulse <= 1'b1;
              r_state             <= DISC;
            end
          end
        end
        TRANS: begin
          if (i_pkt_data_wr) begin
            if (w_cell_full) begin
              r_err <= 1'b1;
              if (!r_err) o_trunc_pulse <= 1'b1;
            end else begin
              ov_pkt_ram_wdata <= iv_pkt_data;
              o_pkt_ram_wr     <= 1'b1;
              ov_pkt_ram_waddr <= {r_bufid, r_cnt[CELL_AW-1:0]};
              r_cnt            <= r_cnt + 1'b1;
            end
            if (w_tail) begin
              o_flowid_wr      <= 1'b1;
              ov_flowid        <= r_flowid;
              ov_frag_id       <= r_frag_id;
              o_last_frag_flag <= r_last;
              r_state          <= IDLE;
            end
          end
        end
        DISC: begin
          if (w_tail) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lookup results come back in request order, so the FIFO head owns each result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_queue_ram_wdata    <= '0;
      o_queue_ram_wr        <= 1'b0;
      ov_queue_ram_waddr    <= '0;
      ov_free_bufid         <= '0;
      o_free_bufid_wr       <= 1'b0;
      o_qfull_discard_pulse <= 1'b0;
      o_lookup_err_pulse    <= 1'b0;
    end else begin
      ov_queue_ram_wdata    <= '0;
      o_queue_ram_wr        <= 1'b0;
      ov_queue_ram_waddr    <= '0;
      ov_free_bufid         <= '0;
      o_free_bufid_wr       <= 1'b0;
      o_qfull_discard_pulse <= 1'b0;
      o_lookup_err_pulse    <= 1'b0;
      if (i_queue_id_wr) begin
        if (w_empty) begin
          o_lookup_err_pulse <= 1'b1;
        end else if (w_pop_ent.err || (&iv_queue_usedw)) begin
          ov_free_bufid         <= w_pop_ent.bufid;
          o_free_bufid_wr       <= 1'b1;
          o_qfull_discard_pulse <= 1'b1;
        end else begin
          ov_queue_ram_wdata <= {w_pop_ent.last, w_pop_ent.bufid};
          o_queue_ram_wr     <= 1'b1;
          ov_queue_ram_waddr <= {iv_queue_id, {QDEPTH_AW{1'b0}}} + QAW'(iv_queue_usedw);
        end
      end
    end
  end
endmodule

// File: tb/tb_frag_input_buffer_ctrl.sv
// Directed bench for frag_input_buffer_ctrl: a queue-based fragment model
// checked every cycle, plus literal expectations per scenario.

module tb_frag_input_buffer_ctrl;
  localparam int BUFID_W = 9, CELL_AW = 3, QID_W = 5, QDEPTH_AW = 4, PEND_AW = 2;

  logic         clk = 1'b0, rst_n = 1'b1;
  logic [133:0] iv_pkt_data = '0;
  logic         i_pkt_data_wr = 1'b0;
  logic [8:0]   iv_bufid = '0;
  logic         i_bufid_wr = 1'b0;
  logic [4:0]   iv_queue_id = '0;
  logic [3:0]   iv_queue_usedw = '0;
  logic         i_queue_id_wr = 1'b0;

  logic         o_bufid_ack, o_pkt_ram_wr, o_last_frag_flag, o_flowid_wr;
  logic [133:0] ov_pkt_ram_wdata;
  logic [11:0]  ov_pkt_ram_waddr;
  logic [13:0]  ov_flowid;
  logic [3:0]   ov_frag_id;
  logic [9:0]   ov_queue_ram_wdata;
  logic         o_queue_ram_wr;
  logic [8:0]   ov_queue_ram_waddr;
  logic [8:0]   ov_free_bufid;
  logic         o_free_bufid_wr, o_ibm_discard_pulse, o_trunc_pulse;
  logic         o_qfull_discard_pulse, o_lookup_err_pulse;

  always #5 clk = ~clk;

  frag_input_buffer_ctrl #(.BUFID_W(BUFID_W), .CELL_AW(CELL_AW), .QID_W(QID_W),
                           .QDEPTH_AW(QDEPTH_AW), .PEND_AW(PEND_AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_pkt_data(iv_pkt_data), .i_pkt_data_wr(i_pkt_data_wr),
    .iv_bufid(iv_bufid), .i_bufid_wr(i_bufid_wr), .o_bufid_ack(o_bufid_ack),
    .ov_pkt_ram_wdata(ov_pkt_ram_wdata), .o_pkt_ram_wr(o_pkt_ram_wr),
    .ov_pkt_ram_waddr(ov_pkt_ram_waddr),
    .ov_flowid(ov_flowid), .ov_frag_id(ov_frag_id),
    .o_last_frag_flag(o_last_frag_flag), .o_flowid_wr(o_flowid_wr),
    .iv_queue_id(iv_queue_id), .iv_queue_usedw(iv_queue_usedw),
    .i_queue_id_wr(i_queue_id_wr),
    .ov_queue_ram_wdata(ov_queue_ram_wdata), .o_queue_ram_wr(o_queue_ram_wr),
    .ov_queue_ram_waddr(ov_queue_ram_waddr),
    .ov_free_bufid(ov_free_bufid), .o_free_bufid_wr(o_free_bufid_wr),
    .o_ibm_discard_pulse(o_ibm_discard_pulse), .o_trunc_pulse(o_trunc_pulse),
    .o_qfull_discard_pulse(o_qfull_discard_pulse),
    .o_lookup_err_pulse(o_lookup_err_pulse)
  );

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: fragment mode 0=waiting for head, 1=receiving, 2=dropping
  logic [133:0] e_wdata;
  logic [11:0]  e_waddr;
  logic         e_wr, e_ack, e_fwr, e_lastf, e_qwr, e_freewr, e_disc, e_trunc, e_qfull, e_lerr;
  logic [13:0]  e_flowid;
  logic [3:0]   e_fragid;
  logic [9:0]   e_qwdata;
  logic [8:0]   e_qwaddr, e_free;
  int           m_mode, m_n, m_sz;
  logic [8:0]   m_bufid;
  logic [13:0]  m_flowid;
  logic [3:0]   m_fragid;
  logic         m_last, m_err;
  logic [10:0]  m_ent;
  logic [10:0]  pq[$];

  always @(posedge clk or negedge rst_n) begin
    e_wdata = '0; e_waddr = '0; e_wr = 0; e_ack = 0; e_fwr = 0; e_lastf = 0;
    e_flowid = '0; e_fragid = '0; e_qwr = 0; e_qwdata = '0; e_qwaddr = '0;
    e_freewr = 0; e_free = '0; e_disc = 0; e_trunc = 0; e_qfull = 0; e_lerr = 0;
    if (!rst_n) begin
      m_mode = 0; m_n = 0; m_err = 0;
      pq.delete();
    end else begin
      m_sz = pq.size();
      if (i_queue_id_wr) begin
        if (m_sz == 0) e_lerr = 1;
        else begin
          m_ent = pq.pop_front();
          if (m_ent[10] || iv_queue_usedw == 4'hF) begin
            e_freewr = 1; e_free = m_ent[8:0]; e_qfull = 1;
          end else begin
            e_qwr = 1; e_qwdata = m_ent[9:0];
            e_qwaddr = 9'(iv_queue_id) * 9'd16 + 9'(iv_queue_usedw);
          end
        end
      end
      if (i_pkt_data_wr) begin
        case (m_mode)
          0: if (iv_pkt_data[133:132] == 2'b01) begin
            if (i_bufid_wr && m_sz < 4) begin
              e_wr = 1; e_ack = 1; e_wdata = iv_pkt_data;
              e_waddr = 12'(iv_bufid) * 12'd8;
              m_bufid = iv_bufid; m_flowid = iv_pkt_data[124:111];
              m_fragid = iv_pkt_data[93:90]; m_last = iv_pkt_data[94];
              m_n = 1; m_err = 0; m_mode = 1;
            end else begin
              e_disc = 1; m_mode = 2;
            end
          end
          1: begin
            if (m_n < 8) begin
              e_wr = 1; e_wdata = iv_pkt_data;
              e_waddr = 12'(m_bufid) * 12'd8 + 12'(m_n);
              m_n++;
            end else begin
              if (!m_err) e_trunc = 1;
              m_err = 1;
            end
            if (iv_pkt_data[133:132] == 2'b10) begin
              e_fwr = 1; e_flowid = m_flowid; e_fragid = m_fragid; e_lastf = m_last;
              pq.push_back({m_err, m_last, m_bufid});
              m_mode = 0;
            end
          end
          default: if (iv_pkt_data[133:132] == 2'b10) m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("pkt_wr_addr", {o_pkt_ram_wr, ov_pkt_ram_waddr}, {e_wr, e_waddr});
    check("pkt_wdata", ov_pkt_ram_wdata, e_wdata);
    check("bufid_ack", o_bufid_ack, e_ack);
    check("lookup_req", {o_flowid_wr, o_last_frag_flag, ov_frag_id, ov_flowid},
          {e_fwr, e_lastf, e_fragid, e_flowid});
    check("queue_wr", {o_queue_ram_wr, ov_queue_ram_waddr, ov_queue_ram_wdata},
          {e_qwr, e_qwaddr, e_qwdata});
    check("free_bufid", {o_free_bufid_wr, ov_free_bufid}, {e_freewr, e_free});
    check("pulses", {o_ibm_discard_pulse, o_trunc_pulse, o_qfull_discard_pulse, o_lookup_err_pulse},
          {e_disc, e_trunc, e_qfull, e_lerr});
  end

  // Event logs for literal per-scenario expectations
  logic [11:0] pw_log[$];
  logic [18:0] qw_log[$];
  logic [8:0]  fr_log[$];
  int ack_cnt, disc_cnt, trunc_cnt, qfull_cnt, lerr_cnt, fwr_cnt;

  always @(negedge clk) begin
    if (o_pkt_ram_wr) pw_log.push_back(ov_pkt_ram_waddr);
    if (o_queue_ram_wr) qw_log.push_back({ov_queue_ram_waddr, ov_queue_ram_wdata});
    if (o_free_bufid_wr) fr_log.push_back(ov_free_bufid);
    if (o_bufid_ack) ack_cnt++;
    if (o_ibm_discard_pulse) disc_cnt++;
    if (o_trunc_pulse) trunc_cnt++;
    if (o_qfull_discard_pulse) qfull_cnt++;
    if (o_lookup_err_pulse) lerr_cnt++;
    if (o_flowid_wr) fwr_cnt++;
  end

  task automatic clear_logs();
    pw_log.delete(); qw_log.delete(); fr_log.delete();
    ack_cnt = 0; disc_cnt = 0; trunc_cnt = 0; qfull_cnt = 0; lerr_cnt = 0; fwr_cnt = 0;
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  function automatic logic [133:0] head_beat(input logic [13:0] fl, input logic last, input logic [3:0] fid);
    logic [133:0] d;
    d = '0; d[133:132] = 2'b01; d[124:111] = fl; d[94] = last; d[93:90] = fid; d[15:0] = 16'hABCD;
    return d;
  endfunction

  function automatic logic [133:0] body_beat(input logic [1:0] typ, input int i);
    logic [133:0] d;
    d = '0; d[133:132] = typ; d[31:0] = 32'(i) ^ 32'h5A5A_0000;
    return d;
  endfunction

  task automatic idle_in();
    iv_pkt_data = '0; i_pkt_data_wr = 0; iv_bufid = '0; i_bufid_wr = 0;
    iv_queue_id = '0; iv_queue_usedw = '0; i_queue_id_wr = 0;
  endtask

  task automatic beat(input logic [133:0] d, input logic bv, input logic [8:0] b);
    iv_pkt_data = d; i_pkt_data_wr = 1; i_bufid_wr = bv; iv_bufid = b;
    tick();
  endtask

  task automatic send_frag(input logic [8:0] b, input logic bv, input logic [13:0] fl,
                           input logic last, input logic [3:0] fid, input int n);
    beat(head_beat(fl, last, fid), bv, b);
    for (int i = 1; i < n - 1; i++) beat(body_beat(2'b11, i), 1'b0, '0);
    beat(body_beat(2'b10, n - 1), 1'b0, '0);
  endtask

  task automatic lookup(input logic [4:0] q, input logic [3:0] u);
    iv_queue_id = q; iv_queue_usedw = u; i_queue_id_wr = 1;
    tick();
    idle_in();
  endtask

  initial begin
    #1 rst_n = 0;
    #1 chk_en = 1;
    tick(); tick();
    check("rst_pkt_wr", {o_pkt_ram_wr, ov_pkt_ram_waddr}, 0);
    check("rst_flowid_wr", {o_flowid_wr, ov_flowid}, 0);
    rst_n = 1;
    tick();

    // Single 4-beat fragment, bufid 0x05
    clear_logs();
    beat(head_beat(14'h1234, 1'b1, 4'hA), 1'b1, 9'h005);
    check("s1_ack_t1", {o_bufid_ack, o_pkt_ram_wr, ov_pkt_ram_waddr}, {2'b11, 12'h028});
    beat(body_beat(2'b11, 1), 1'b0, '0);
    beat(body_beat(2'b11, 2), 1'b0, '0);
    beat(body_beat(2'b10, 3), 1'b0, '0);
    check("s1_tail_wr", {o_pkt_ram_wr, ov_pkt_ram_waddr}, {1'b1, 12'h02B});
    check("s1_flowid", {o_flowid_wr, o_last_frag_flag, ov_frag_id, ov_flowid}, {2'b11, 4'hA, 14'h1234});
    idle_in(); tick(); tick();
    check("s1_nwr", pw_log.size(), 4);
    check("s1_first_addr", pw_log[0], 12'h028);
    check("s1_ack_cnt", ack_cnt, 1);
    lookup(5'd3, 4'd2);
    check("s1_qwr", {o_queue_ram_wr, ov_queue_ram_waddr, ov_queue_ram_wdata}, {1'b1, 9'h032, 10'h205});
    tick();
    check("s1_qlog", qw_log.size(), 1);

    // No bufid, then a back-to-back accepted fragment
    clear_logs();
    send_frag(9'h000, 1'b0, 14'h0111, 1'b0, 4'h1, 3);
    send_frag(9'h007, 1'b1, 14'h0222, 1'b0, 4'h3, 3);
    idle_in(); tick(); tick();
    check("s2_disc", disc_cnt, 1);
    check("s2_nwr", pw_log.size(), 3);
    check("s2_addr0", pw_log[0], 12'h038);
    lookup(5'd1, 4'd0); tick();
    check("s2_q", qw_log[0], {9'h010, 10'h007});

    // Overlength 10-beat fragment
    clear_logs();
    send_frag(9'h011, 1'b1, 14'h0333, 1'b1, 4'h2, 10);
    idle_in(); tick(); tick();
    check("s3_nwr", pw_log.size(), 8);
    check("s3_last_addr", pw_log[7], 12'h08F);
    check("s3_trunc", trunc_cnt, 1);
    lookup(5'd4, 4'd1); tick();
    check("s3_free", {fr_log.size(), fr_log[0]}, {32'd1, 9'h011});
    check("s3_noq", {qw_log.size(), qfull_cnt}, {32'd0, 32'd1});

    // Queue full
    clear_logs();
    send_frag(9'h022, 1'b1, 14'h0444, 1'b0, 4'h4, 3);
    idle_in(); tick(); tick();
    lookup(5'd6, 4'hF); tick();
    check("s4_free", {fr_log.size(), fr_log[0]}, {32'd1, 9'h022});
    check("s4_noq", {qw_log.size(), qfull_cnt}, {32'd0, 32'd1});

    // Pending FIFO full, in-order results, then result with empty FIFO
    clear_logs();
    for (int k = 0; k < 4; k++)
      send_frag(9'(48 + k), 1'b1, 14'(k + 16), k[0], 4'(k), 3);
    send_frag(9'h034, 1'b1, 14'h0999, 1'b0, 4'h9, 3);
    idle_in(); tick(); tick();
    check("s5_disc", disc_cnt, 1);
    check("s5_fwr", fwr_cnt, 4);
    check("s5_nwr", pw_log.size(), 12);
    for (int k = 0; k < 4; k++) lookup(5'd2, 4'(k));
    tick();
    check("s5_nq", qw_log.size(), 4);
    for (int k = 0; k < 4; k++)
      check("s5_q_order", qw_log[k], {9'(32 + k), k[0], 9'(48 + k)});
    lookup(5'd0, 4'd0); tick();
    check("s5_lerr", {lerr_cnt, qw_log.size()}, {32'd1, 32'd4});

    // Tail push coincides with a pop
    clear_logs();
    send_frag(9'h040, 1'b1, 14'h0555, 1'b1, 4'h5, 2);
    idle_in(); tick();
    beat(head_beat(14'h0666, 1'b0, 4'h6), 1'b1, 9'h041);
    iv_queue_id = 5'd7; iv_queue_usedw = 4'd3; i_queue_id_wr = 1;
    beat(body_beat(2'b10, 1), 1'b0, '0);
    idle_in(); tick();
    lookup(5'd8, 4'd5); tick();
    check("s6_nq", {qw_log.size(), lerr_cnt}, {32'd2, 32'd0});
    check("s6_q0", qw_log[0], {9'h073, 10'h240});
    check("s6_q1", qw_log[1], {9'h085, 10'h041});

    // Reset mid-fragment clears FIFO; residual beats ignored
    clear_logs();
    send_frag(9'h04F, 1'b1, 14'h0777, 1'b0, 4'h7, 2);
    idle_in(); tick();
    beat(head_beat(14'h0888, 1'b1, 4'h8), 1'b1, 9'h050);
    beat(body_beat(2'b11, 1), 1'b0, '0);
    rst_n = 0;
    #1;
    check("s7_rst_pkt", {o_pkt_ram_wr, ov_pkt_ram_waddr, o_bufid_ack}, 0);
    check("s7_rst_lookup", {o_flowid_wr, ov_flowid, ov_frag_id}, 0);
    tick();
    rst_n = 1;
    beat(body_beat(2'b11, 2), 1'b0, '0);
    beat(body_beat(2'b10, 3), 1'b0, '0);
    idle_in(); tick(); tick();
    check("s7_nwr", pw_log.size(), 4);
    check("s7_fwr", fwr_cnt, 1);
    lookup(5'd1, 4'd1); tick();
    check("s7_fifo_empty", {lerr_cnt, qw_log.size()}, {32'd1, 32'd0});

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frag_input_buffer_ctrl.md
# frag_input_buffer_ctrl

Parametrised input-buffer manager for the HCP last-node regroup path, sitting between the PDM packet stream, the PBM buffer pool, the flow table and the queue RAM. It writes each fragment into a PBM cell addressed by an allocated bufid and tracks buffer accesses through a pending-lookup FIFO. It issues one flow-table lookup per completed fragment and enqueues `{last_frag_flag, bufid}` at the returned queue position. Unlike the previous generation it:
- has configurable buffer, queue and pending depths;
- truncates overlength fragments;
- supports several outstanding lookups;
- returns bufids to PBM when a fragment cannot be enqueued.

## Interface
Parameters:
- BUFID_W, 9, bufid width
- CELL_AW, 3, beats-per-cell address bits; a cell holds at most 2^CELL_AW beats
- QID_W, 5, queue id width
- QDEPTH_AW, 4, queue depth address bits; usedw width
- PEND_AW, 2, pending FIFO depth = 2^PEND_AW

Ports:
- i_clk  in  1  clock; the only clock
- i_rst_n  in  1  reset, asynchronous, active-low
- iv_pkt_data  in  134  beat; [133:132] 01 head, 11 middle, 10 tail; head fields: flowid [124:111], last_frag [94], frag_id [93:90]
- i_pkt_data_wr  in  1  beat valid
- iv_bufid  in  BUFID_W  free bufid from PBM
- i_bufid_wr  in  1  iv_bufid valid; 0 means pool empty
- o_bufid_ack  out  1  one-cycle pulse, bufid consumed
- ov_pkt_ram_wdata / o_pkt_ram_wr / ov_pkt_ram_waddr  out  134 / 1 / BUFID_W+CELL_AW  PBM write port
- ov_flowid / ov_frag_id / o_last_frag_flag / o_flowid_wr  out  14 / 4 / 1 / 1  lookup request
- iv_queue_id / iv_queue_usedw / i_queue_id_wr  in  QID_W / QDEPTH_AW / 1  lookup result, in request order
- ov_queue_ram_wdata / o_queue_ram_wr / ov_queue_ram_waddr  out  BUFID_W+1 / 1 / QID_W+QDEPTH_AW  queue RAM write
- ov_free_bufid / o_free_bufid_wr  out  BUFID_W / 1  bufid returned to PBM
- o_ibm_discard_pulse  out  1  fragment dropped at head (no bufid or pending FIFO full)
- o_trunc_pulse  out  1  fragment exceeded cell size
- o_qfull_discard_pulse  out  1  enqueue refused (queue full or truncated)
- o_lookup_err_pulse  out  1  lookup result with empty pending FIFO

## Operation
- **Reset:** every output register is 0, the state is IDLE and the pending FIFO is empty.
- **FSM states:** IDLE, TRANS, DISC.
- **IDLE, head beat:**
  - Accept when i_bufid_wr=1 and the pending FIFO is not full.
  - On accept: write the beat at {iv_bufid, CELL_AW'b0}, pulse o_bufid_ack, latch bufid, flowid, frag_id and last_frag, set beat count to 1, go to TRANS.
  - Otherwise: pulse o_ibm_discard_pulse, no ack, go to DISC.
- **IDLE, non-head beat:** ignored; stay in IDLE.
- **TRANS:**
  - Each beat writes at waddr+1 and increments the count (width CELL_AW+1).
  - If a beat arrives while count = 2^CELL_AW, it is not written; set the err flag and pulse o_trunc_pulse once per fragment.
  - On the tail beat, go to IDLE and finish the fragment.
- **DISC:** drop beats with no writes; the tail beat returns the FSM to IDLE.
- **Finishing a fragment** happens on the cycle after the tail beat:
  - pulse o_flowid_wr with the latched fields;
  - push {err, last_frag, bufid} into the pending FIFO.
- **Lookup result** (i_queue_id_wr=1): pop the pending FIFO.
  - If err=1 or iv_queue_usedw = all ones: drive ov_free_bufid=bufid, pulse o_free_bufid_wr and o_qfull_discard_pulse, no queue write.
  - Otherwise: write ov_queue_ram_wdata={last_frag, bufid} at ov_queue_ram_waddr={iv_queue_id, QDEPTH_AW'b0} + usedw (zero-extended).
- **Pending FIFO empty on a result:** pulse o_lookup_err_pulse, no write, no pop.
- **Simultaneous push and pop:** allowed; the occupancy is unchanged.
- **Idle outputs:** outputs not written in a cycle return to 0 (data, address and strobes), except the latched lookup fields, which are cleared after their pulse.

## Timing
- **Head beat at cycle t:** o_pkt_ram_wr and o_bufid_ack at t+1.
- **Beat n:** written at t+n.
- **Tail beat at cycle t_e:** last RAM write at t_e+1; o_flowid_wr and the FIFO push at t_e+1.
- **i_queue_id_wr at cycle r:** queue RAM write or bufid free at r+1.
- **Back-to-back fragments:** a head beat on the cycle after a tail beat is accepted with no bubble.
- **Throughput:** full, one beat per cycle.
- **Reset mid-fragment:** all state is cleared, and the remaining beats of that fragment are ignored until the next head beat. Bufids already acked are lost; PBM recovers them through its own reset.

## Test plan
- **Single fragment:** 4-beat fragment, bufid=0x05, CELL_AW=3 -> writes at 0x028..0x02B; ack at t+1; o_flowid_wr at tail+1. Lookup qid=3, usedw=2 -> queue write at addr 0x032, data {last_frag, 0x05}.
- **No bufid:** head beat with i_bufid_wr=0 -> o_ibm_discard_pulse, no writes. Next fragment with a bufid is accepted normally.
- **Overlength:** 10-beat fragment, CELL_AW=3 -> 8 writes, one o_trunc_pulse. Its lookup result -> o_free_bufid_wr with that bufid, no queue write.
- **Queue full:** usedw=0xF -> bufid freed, o_qfull_discard_pulse, no queue write.
- **Pending FIFO full:** 4 fragments with lookups withheld -> 5th head beat discarded. Results returned in order -> enqueues match push order. A result arriving with the FIFO empty -> o_lookup_err_pulse.
- **Reset mid-fragment:** assert i_rst_n=0 during TRANS -> all outputs 0, FIFO empty. The residual tail beat is ignored.
